// File: rtl/asic_cpu_pkg.sv
// Shared definitions for the minimal RV32I-subset fetch/execute core:
// opcodes, funct3/funct7 constants, FSM state type and the canonical NOP.
package asic_cpu_pkg;

    localparam logic [6:0] OP_IMM = 7'h13;
    localparam logic [6:0] OP     = 7'h33;
    localparam logic [6:0] LUI    = 7'h37;
    localparam logic [6:0] AUIPC  = 7'h17;
    localparam logic [6:0] JAL    = 7'h6F;
    localparam logic [6:0] JALR   = 7'h67;
    localparam logic [6:0] BRANCH = 7'h63;

    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;
    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_JALR = 3'b000;

    localparam logic [6:0] F7_BASE = 7'h00;
    localparam logic [6:0] F7_SUB  = 7'h20;

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic [1:0] {
        StReset,
        StFetch,
        StExec,
        StTrap
    } state_e;

endpackage

// File: rtl/asic_cpu_core.sv
// Two-cycle fetch/execute RV32I-subset core: FSM, register file and ALU.
// Optional macro ASIC_TOP_ILLEGAL_TRAP_EN: unsupported encodings trap instead of acting as NOP.
module asic_cpu_core
    import asic_cpu_pkg::*;
#(
    parameter logic [31:0] PROGADDR_RESET = 32'h0000_0000,
    parameter int unsigned REG_COUNT      = 32
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata,
    output logic        mem_valid,
    output logic [31:0] mem_addr,
    output logic        mem_instr,
    output logic        trap
);

`ifdef ASIC_TOP_ILLEGAL_TRAP_EN
    localparam bit IllegalTrap = 1'b1;
`else
    localparam bit IllegalTrap = 1'b0;
`endif

    state_e      state;
    logic [31:0] pc;
    logic [31:0] ir;
    logic [31:0] regs [REG_COUNT];

    logic [6:0]  opcode;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] imm_i, imm_u, imm_j, imm_b;
    logic [31:0] rs1_val, rs2_val, pc_plus4;
    logic [31:0] wdata, next_pc;
    logic        wen, illegal, jump, misaligned, trap_now, rf_we;

    assign opcode = ir[6:0];
    assign rd     = ir[11:7];
    assign funct3 = ir[14:12];
    assign rs1    = ir[19:15];
    assign rs2    = ir[24:20];
    assign funct7 = ir[31:25];
    assign imm_i  = {{20{ir[31]}}, ir[31:20]};
    assign imm_u  = {ir[31:12], 12'b0};
    assign imm_j  = {{12{ir[31]}}, ir[19:12], ir[20], ir[30:21], 1'b0};
    assign imm_b  = {{20{ir[31]}}, ir[7], ir[30:25], ir[11:8], 1'b0};

    assign rs1_val  = (rs1 == 5'd0) ? 32'd0 : regs[rs1];
    assign rs2_val  = (rs2 == 5'd0) ? 32'd0 : regs[rs2];
    assign pc_plus4 = pc + 32'd4;

    always_comb begin
        wdata   = '0;
        wen     = 1'b0;
        illegal = 1'b0;
        jump    = 1'b0;
        next_pc = pc_plus4;
        case (opcode)
            OP_IMM: begin
                wen = 1'b1;
                case (funct3)
                    F3_ADD:  wdata = rs1_val + imm_i;
                    F3_SLT:  wdata = {31'b0, $signed(rs1_val) < $signed(imm_i)};
                    F3_SLTU: wdata = {31'b0, rs1_val < imm_i};
                    F3_XOR:  wdata = rs1_val ^ imm_i;
                    F3_OR:   wdata = rs1_val | imm_i;
                    F3_AND:  wdata = rs1_val & imm_i;
                    default: begin wen = 1'b0; illegal = 1'b1; end
                endcase
            end
            OP: begin
                wen = 1'b1;
                if (funct3 == F3_ADD && funct7 == F7_SUB) begin
                    wdata = rs1_val - rs2_val;
                end else if (funct7 != F7_BASE) begin
                    wen     = 1'b0;
                    illegal = 1'b1;
                end else begin
                    case (funct3)
                        F3_ADD:  wdata = rs1_val + rs2_val;
                        F3_XOR:  wdata = rs1_val ^ rs2_val;
                        F3_OR:   wdata = rs1_val | rs2_val;
                        F3_AND:  wdata = rs1_val & rs2_val;
                        default: begin wen = 1'b0; illegal = 1'b1; end
                    endcase
                end
            end
            LUI: begin
                wen   = 1'b1;
                wdata = imm_u;
            end
            AUIPC: begin
                wen   = 1'b1;
                wdata = pc + imm_u;
            end
            JAL: begin
                wen     = 1'b1;
                wdata   = pc_plus4;
                jump    = 1'b1;
                next_pc = pc + imm_j;
            end
            JALR: begin
                if (funct3 == F3_JALR) begin
                    wen     = 1'b1;
                    wdata   = pc_plus4;
                    jump    = 1'b1;
                    next_pc = (rs1_val + imm_i) & ~32'd1;
                end else begin
                    illegal = 1'b1;
                end
            end
            BRANCH: begin
                if (funct3 == F3_BEQ || funct3 == F3_BNE) begin
                    jump = (rs1_val == rs2_val) ^ (funct3 == F3_BNE);
                    if (jump) next_pc = pc + imm_b;
                end else begin
                    illegal = 1'b1;
                end
            end
            default: illegal = 1'b1;
        endcase
    end

    // Only taken control transfers can produce an unaligned pc.
    assign misaligned = jump && (next_pc[1:0] != 2'b00);
    assign trap_now   = misaligned || (IllegalTrap && illegal);
    assign rf_we      = (state == StExec) && wen && !trap_now && (rd != 5'd0);

    always_ff @(posedge clk) begin
        if (rf_we) regs[rd] <= wdata;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state     <= StReset;
            pc        <= PROGADDR_RESET;
            ir        <= NOP;
            mem_valid <= 1'b0;
            mem_instr <= 1'b0;
            mem_addr  <= PROGADDR_RESET;
            trap      <= 1'b0;
        end else begin
            case (state)
                StReset: begin
                    state     <= StFetch;
                    mem_valid <= 1'b1;
                    mem_instr <= 1'b1;
                    mem_addr  <= pc;
                end
                StFetch: begin
                    if (mem_ready) begin
                        ir        <= mem_rdata;
                        mem_valid <= 1'b0;
                        mem_instr <= 1'b0;
                        state     <= StExec;
                    end
                end
                StExec: begin
                    if (trap_now) begin
                        trap  <= 1'b1;
                        state <= StTrap;
                    end else begin
                        pc        <= next_pc;
                        mem_addr  <= next_pc;
                        mem_valid <= 1'b1;
                        mem_instr <= 1'b1;
                        state     <= StFetch;
                    end
                end
                default: begin
                    mem_valid <= 1'b0;
                    mem_instr <= 1'b0;
                    trap      <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: rtl/asic_cpu_top.sv
// Chip-level wrapper: connects the memory handshake and trap pins to u_core.
// Honours macro ASIC_TOP_ILLEGAL_TRAP_EN through the core.
module asic_cpu_top
    import asic_cpu_pkg::*;
#(
    parameter logic [31:0] PROGADDR_RESET = 32'h0000_0000,
    parameter int unsigned REG_COUNT      = 32
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata,
    output logic        mem_valid,
    output logic [31:0] mem_addr,
    output logic        mem_instr,
    output logic        trap
);

    asic_cpu_core #(
        .PROGADDR_RESET (PROGADDR_RESET),
        .REG_COUNT      (REG_COUNT)
    ) u_core (
        .clk       (clk),
        .resetn    (resetn),
        .mem_ready (mem_ready),
        .mem_rdata (mem_rdata),
        .mem_valid (mem_valid),
        .mem_addr  (mem_addr),
        .mem_instr (mem_instr),
        .trap      (trap)
    );

endmodule

// File: tb/tb_asic_cpu_top.sv
// Directed bench for asic_cpu_top: fetch stream, stalls, branches, traps, async reset.
module tb_asic_cpu_top;
    import asic_cpu_pkg::*;

    logic        clk = 1'b0;
    logic        resetn;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic        mem_valid;
    logic [31:0] mem_addr;
    logic        mem_instr;
    logic        trap;

    int n_checks = 0;
    int n_fails  = 0;

    asic_cpu_top #(
        .PROGADDR_RESET (32'h0000_0000),
        .REG_COUNT      (32)
    ) dut (
        .clk       (clk),
        .resetn    (resetn),
        .mem_ready (mem_ready),
        .mem_rdata (mem_rdata),
        .mem_valid (mem_valid),
        .mem_addr  (mem_addr),
        .mem_instr (mem_instr),
        .trap      (trap)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge of the following EXEC cycle.
    task automatic do_fetch(input logic [31:0] word, input logic [31:0] exp_addr,
                            input string tag);
        int n = 0;
        while (!mem_valid && n < 10) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_valid"}, {31'b0, mem_valid}, 32'd1);
        check({tag, "_addr"}, mem_addr, exp_addr);
        check({tag, "_instr"}, {31'b0, mem_instr}, 32'd1);
        mem_ready = 1'b1;
        mem_rdata = word;
        @(negedge clk);
        mem_ready = 1'b0;
        mem_rdata = 32'hDEAD_BEEF;
        check({tag, "_exec_valid"}, {31'b0, mem_valid}, 32'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        resetn = 1'b0;
        repeat (2) @(negedge clk);
        resetn = 1'b1;
    endtask

    initial begin
        logic [31:0] exp_addr;
        int          hs;

        resetn    = 1'b0;
        mem_ready = 1'b0;
        mem_rdata = NOP;
        repeat (20) @(negedge clk);
        check("rst_valid", {31'b0, mem_valid}, 32'd0);
        check("rst_instr", {31'b0, mem_instr}, 32'd0);
        check("rst_trap", {31'b0, trap}, 32'd0);
        check("rst_addr", mem_addr, 32'h0);

        resetn = 1'b1;
        @(negedge clk);
        check("first_valid", {31'b0, mem_valid}, 32'd1);
        check("first_addr", mem_addr, 32'h0);

        // Memory not ready: request must hold steady.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("stall_valid", {31'b0, mem_valid}, 32'd1);
            check("stall_addr", mem_addr, 32'h0);
        end

        mem_ready = 1'b1;
        mem_rdata = NOP;
        exp_addr  = 32'h0;
        hs        = 0;
        for (int i = 0; i < 500; i++) begin
            if (mem_valid) begin
                check("nop_addr", mem_addr, exp_addr);
                exp_addr += 32'd4;
                hs++;
            end
            @(negedge clk);
        end
        mem_ready = 1'b0;
        check("nop_fetches", hs, 32'd250);
        check("nop_trap", {31'b0, trap}, 32'd0);

        do_fetch(32'h0050_0093, 32'h0000_03E8, "addi");
        do_fetch(32'h0010_8463, 32'h0000_03EC, "beq");
        // BNE x1,x0,+8 is taken only if ADDI really wrote x1=5.
        do_fetch(32'h0000_9463, 32'h0000_03F4, "bne");
        do_fetch(32'h0020_006F, 32'h0000_03FC, "jal");
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("jal_trap", {31'b0, trap}, 32'd1);
            check("jal_valid", {31'b0, mem_valid}, 32'd0);
        end

        do_reset();
        #1;
        check("rst2_trap", {31'b0, trap}, 32'd0);
        do_fetch(32'hFFFF_FFFF, 32'h0, "illegal");
        @(negedge clk);
`ifdef ASIC_TOP_ILLEGAL_TRAP_EN
        check("illegal_trap", {31'b0, trap}, 32'd1);
        check("illegal_valid", {31'b0, mem_valid}, 32'd0);
`else
        check("illegal_trap", {31'b0, trap}, 32'd0);
        check("illegal_next", mem_addr, 32'h4);
`endif

        do_reset();
        do_fetch(NOP, 32'h0, "pre_midrst");
        @(negedge clk);
        check("midrst_pre_addr", mem_addr, 32'h4);
        #2;
        resetn = 1'b0;
        #1;
        check("midrst_valid", {31'b0, mem_valid}, 32'd0);
        check("midrst_addr", mem_addr, 32'h0);
        check("midrst_instr", {31'b0, mem_instr}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/asic_cpu_top.md
Name: asic_cpu_top

Overview:
- Top-level ASIC wrapper around a minimal RV32I-subset instruction-fetch/execute core, instantiated as u_core.
- Talks to an external single-port memory through a valid/ready handshake.
- Sits at chip level; the memory model or SRAM macro lives outside.
- Design goal: demonstrate a live fetch stream. A NOP-only memory makes the core fetch sequential addresses forever.

Parameters:
- PROGADDR_RESET, 32'h0000_0000, first fetch address after reset.
- REG_COUNT, 32, architectural registers (x0 hardwired to zero).

Ports:
- clk  in  1  single system clock, rising edge.
- resetn  in  1  asynchronous active-low reset.
- mem_ready  in  1  memory accepts/answers the current request this cycle.
- mem_rdata  in  32  instruction word returned by memory; valid when mem_ready=1.
- mem_valid  out  1  request outstanding.
- mem_addr  out  32  word-aligned fetch address (bits [1:0]=0).
- mem_instr  out  1  request is an instruction fetch (always 1 when mem_valid=1).
- trap  out  1  core halted on illegal or misaligned instruction.

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-low (resetn).
- Reset values: mem_valid=0, mem_instr=0, trap=0, mem_addr=PROGADDR_RESET, pc=PROGADDR_RESET, state=RESET. Register file contents are not reset; x0 always reads 0.
- FSM states: RESET, FETCH, EXEC, TRAP.
  - RESET: on the first clk edge after resetn deasserts, go to FETCH.
  - FETCH: mem_valid=1, mem_instr=1, mem_addr=pc. Hold all three stable until mem_valid&&mem_ready. On handshake, latch mem_rdata into the instruction register, drop mem_valid next cycle, go to EXEC.
  - EXEC (exactly one cycle, mem_valid=0): decode and execute, update pc, return to FETCH.
  - TRAP: mem_valid=0, trap=1. Exit only via reset.
- Throughput: with mem_ready tied high, one instruction per 2 cycles, so mem_addr advances by 4 on every fetch.
- Supported instructions:
  - OP-IMM: ADDI, ANDI, ORI, XORI, SLTI, SLTIU.
  - OP: ADD, SUB, AND, OR, XOR.
  - LUI, AUIPC, JAL, JALR, BEQ, BNE.
- Arithmetic and pc:
  - All arithmetic is 32-bit, wrap-around; overflow is ignored.
  - Immediates are sign-extended per RV32I.
  - Default next pc = pc+4; pc wraps from 32'hFFFF_FFFC to 0.
  - JALR target has bit0 cleared.
- Misaligned target (bits[1:0]≠0 after jump/branch): trap.
- Writes to x0 are discarded.
- Simultaneous events: mem_ready while mem_valid=0 is ignored. mem_rdata is sampled only on the handshake cycle.
- Reset mid-fetch: outputs return to reset values immediately (asynchronous); the outstanding request is abandoned.

Optional Feature:
- Macro ASIC_TOP_ILLEGAL_TRAP_EN.
  - Defined: any unsupported opcode or funct encoding in EXEC enters TRAP (trap=1, mem_valid=0).
  - Undefined: unsupported encodings execute as NOP (pc+=4, no register write). trap can still assert on misaligned targets.

Decomposition:
- Shared package asic_cpu_pkg: opcode localparams (OP_IMM=7'h13, OP=7'h33, LUI=7'h37, AUIPC=7'h17, JAL=7'h6F, JALR=7'h67, BRANCH=7'h63), funct3 constants, the state enum, and the NOP constant 32'h0000_0013.
- Sub-module asic_cpu_core, instance name u_core.
  - Contains the FSM, register file and ALU.
  - Its internal mem_valid and mem_addr signals carry exactly those names, for hierarchical probing by verification.
- asic_cpu_top only connects ports to u_core.

Test Plan:
- Reset hold 20 cycles, then mem_ready=1, mem_rdata=32'h0000_0013 for 500 cycles -> addresses 0x0,0x4,0x8,... each new; at least 10 (expected ~249) distinct fetch addresses; trap=0.
- mem_ready low for 3 cycles during FETCH -> mem_valid and mem_addr held stable; advance only after mem_ready=1.
- Feed ADDI x1,x0,5 (32'h0050_0093) then BEQ x1,x1,+8 (32'h0010_8463) -> next fetch address = branch pc+8.
- Feed JAL x0,+2 (32'h0020_006F) -> trap=1, mem_valid stays 0.
- Feed 32'hFFFF_FFFF:
  - With ASIC_TOP_ILLEGAL_TRAP_EN: trap=1.
  - Without: next fetch at pc+4.
- Assert resetn low mid-FETCH -> mem_valid=0 and mem_addr=PROGADDR_RESET without waiting for a clock edge.
